// File: rtl/ui_acc_reduce.sv
// ui_acc_reduce: streaming unsigned reduction of a len-operand burst,
// sum modulo 2^N with a sticky carry flag, result held on a valid/ready port.
module ui_acc_reduce #(
  parameter int unsigned N  = 64,
  parameter int unsigned LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_ovf,
  output logic          busy
);

  localparam int unsigned SW = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [SW-1:0] sum;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state and accumulate logic; carry out of bit N-1 lands in sum[N]
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    sum     = SW'(acc_q) + SW'(in_data);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = sum[N-1:0];
          ovf_d = ovf_q | sum[N];
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers or a decode of the state register
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_ui_acc_reduce.sv
// Bench for ui_acc_reduce: a 64-bit and an 8-bit instance run in lockstep on
// shared stimulus and are checked against a queue-based arithmetic reference.
module tb_ui_acc_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready_w, out_valid_w, out_ovf_w, busy_w;
  logic [63:0] out_data_w;
  logic        in_ready_n, out_valid_n, out_ovf_n, busy_n;
  logic [7:0]  out_data_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ui_acc_reduce #(.N(64), .LW(16)) dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .busy(busy_w)
  );

  ui_acc_reduce #(.N(8), .LW(16)) dut_n (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data[7:0]),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .out_ovf(out_ovf_n), .busy(busy_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sum as plain integers, flag set if any running total exceeds the word
  task automatic ref_model(input logic [63:0] beats[$],
                           output logic [63:0] s64, output logic o64,
                           output logic [7:0] s8, output logic o8);
    logic [64:0] t64;
    int unsigned t8;
    s64 = '0; o64 = 1'b0; s8 = '0; o8 = 1'b0;
    foreach (beats[i]) begin
      t64 = {1'b0, s64} + {1'b0, beats[i]};
      if (t64 > 65'h0_FFFF_FFFF_FFFF_FFFF) o64 = 1'b1;
      s64 = t64[63:0];
      t8 = int'(s8) + int'(beats[i][7:0]);
      if (t8 > 255) o8 = 1'b1;
      s8 = 8'(t8 % 256);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full burst; entered and left with both instances idle, 1 time unit after an edge
  task automatic burst(input string nm, input int unsigned l, input logic [63:0] beats[$],
                       input int gap, input int hold, input bit poke);
    logic [63:0] s64;
    logic [7:0]  s8;
    logic        o64, o8;
    int          miss;
    ref_model(beats, s64, o64, s8, o8);
    miss = 0;
    check({nm, "_pre_busy"}, 64'(busy_w | busy_n), 64'd0);
    start = 1'b1;
    len   = 16'(l);
    step();
    start = 1'b0;
    len   = 16'($urandom);
    check({nm, "_busy"}, 64'({busy_w, busy_n}), 64'd3);
    if (l == 0) begin
      check({nm, "_len0_ready"}, 64'({in_ready_w, in_ready_n}), 64'd0);
    end else begin
      check({nm, "_in_ready"}, 64'({in_ready_w, in_ready_n}), 64'd3);
      check({nm, "_no_early_valid"}, 64'({out_valid_w, out_valid_n}), 64'd0);
    end
    foreach (beats[i]) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        start    = poke;
        step();
        start    = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = beats[i];
      if (!(in_ready_w && in_ready_n)) miss++;
      step();
      in_valid = 1'b0;
    end
    check({nm, "_beat_ready"}, 64'(miss), 64'd0);
    check({nm, "_out_valid"}, 64'({out_valid_w, out_valid_n}), 64'd3);
    check({nm, "_ready_drop"}, 64'({in_ready_w, in_ready_n}), 64'd0);
    check({nm, "_data64"}, out_data_w, s64);
    check({nm, "_ovf64"}, 64'(out_ovf_w), 64'(o64));
    check({nm, "_data8"}, 64'(out_data_n), 64'(s8));
    check({nm, "_ovf8"}, 64'(out_ovf_n), 64'(o8));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = poke;
      in_valid  = poke;
      in_data   = {$urandom, $urandom};
      step();
      start     = 1'b0;
      in_valid  = 1'b0;
      check({nm, "_hold_valid"}, 64'({out_valid_w, out_valid_n}), 64'd3);
      check({nm, "_hold_data64"}, out_data_w, s64);
      check({nm, "_hold_data8"}, {55'd0, out_ovf_n, out_data_n}, {55'd0, o8, s8});
      check({nm, "_hold_ovf64"}, 64'(out_ovf_w), 64'(o64));
    end
    out_ready = 1'b1;
    start     = poke;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check({nm, "_done_busy"}, 64'({busy_w, busy_n}), 64'd0);
    check({nm, "_done_valid"}, 64'({out_valid_w, out_valid_n}), 64'd0);
  endtask

  initial begin
    logic [63:0] q[$];
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_outputs_w", {in_ready_w, out_valid_w, out_ovf_w, busy_w, out_data_w[59:0]}, 64'd0);
    check("rst_outputs_n", {52'd0, in_ready_n, out_valid_n, out_ovf_n, busy_n, out_data_n}, 64'd0);

    q = '{64'd1, 64'd2, 64'd3, 64'd4};
    burst("b1234", 4, q, 0, 0, 1'b0);

    q = '{64'd200, 64'd100};
    burst("wrap8", 2, q, 0, 0, 1'b0);
    q = '{64'd5};
    burst("clr_flag", 1, q, 0, 0, 1'b0);

    q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd3};
    burst("wrap64", 3, q, 0, 0, 1'b0);

    q.delete();
    burst("len0", 0, q, 0, 1, 1'b0);

    q = '{64'd7, 64'd8, 64'd9};
    burst("gaps", 3, q, 2, 5, 1'b1);

    // Abort after 2 of 5 beats, then confirm no residue
    start = 1'b1; len = 16'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 64'hFF;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_w", {in_ready_w, out_valid_w, out_ovf_w, busy_w, out_data_w[59:0]}, 64'd0);
    check("abort_n", {52'd0, in_ready_n, out_valid_n, out_ovf_n, busy_n, out_data_n}, 64'd0);
    q = '{64'd3, 64'd4};
    burst("post_abort", 2, q, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int unsigned l;
      l = $urandom_range(1, 12);
      q.delete();
      for (int i = 0; i < int'(l); i++) q.push_back({$urandom, $urandom});
      burst($sformatf("rnd%0d", r), l, q, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    q.delete();
    for (int i = 0; i < 65535; i++) q.push_back(64'd1);
    burst("maxlen", 65535, q, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
